// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - HI/LO op codes, FSM states and operand helpers shared with decode and hazard logic
package hilo_pkg;

    localparam int HILO_WIDTH = 32;

    typedef enum logic [2:0] {
        HILO_NOP   = 3'd0,
        HILO_MULT  = 3'd1,
        HILO_MULTU = 3'd2,
        HILO_DIV   = 3'd3,
        HILO_DIVU  = 3'd4,
        HILO_MTHI  = 3'd5,
        HILO_MTLO  = 3'd6
    } hilo_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } hilo_state_e;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == HILO_MULT) || (op == HILO_DIV);
    endfunction

    function automatic logic op_is_mul(input logic [2:0] op);
        return (op == HILO_MULT) || (op == HILO_MULTU);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == HILO_DIV) || (op == HILO_DIVU);
    endfunction

endpackage

// File: rtl/hilo_iter_core.sv
// rtl/hilo_iter_core.sv - one-bit-per-cycle shift-add multiplier / restoring divider datapath
module hilo_iter_core
    import hilo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init,
    input  logic               step,
    input  logic               mode_div,
    input  logic [WIDTH-1:0]   init_lo,
    input  logic [WIDTH-1:0]   init_operand,
    output logic               last_step,
    output logic [2*WIDTH-1:0] acc
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   operand_q, operand_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     diff;
    logic               running;

    assign running = (cnt_q != CW'(WIDTH));

    always_comb begin
        acc_d     = acc_q;
        operand_d = operand_q;
        cnt_d     = cnt_q;

        // Multiply: upper half accumulates the multiplicand, carry shifts in from the top.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, operand_q} : '0);

        // Divide: remainder fits in WIDTH bits, so bit WIDTH of diff is a clean borrow flag.
        rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
        diff      = rem_shift - {1'b0, operand_q};

        if (init) begin
            acc_d     = {{WIDTH{1'b0}}, init_lo};
            operand_d = init_operand;
            cnt_d     = '0;
        end else if (step && running) begin
            if (mode_div) begin
                if (!diff[WIDTH]) begin
                    acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            operand_q <= '0;
            cnt_q     <= '0;
        end else begin
            acc_q     <= acc_d;
            operand_q <= operand_d;
            cnt_q     <= cnt_d;
        end
    end

    assign last_step = step && (cnt_q == CW'(WIDTH - 1));
    assign acc       = acc_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - HI/LO writer: MULT/MULTU/DIV/DIVU/MTHI/MTLO with registered HI and LO
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    hilo_state_e state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic             pend_dbz_q, pend_dbz_d;
    logic             div_q, div_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic               core_init;
    logic               core_step;
    logic               core_mode_div;
    logic [WIDTH-1:0]   core_lo;
    logic [WIDTH-1:0]   core_operand;
    logic               core_last;
    logic [2*WIDTH-1:0] core_acc;

    logic               sgn;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    hilo_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk          (clk),
        .rst_n        (rst_n),
        .init         (core_init),
        .step         (core_step),
        .mode_div     (core_mode_div),
        .init_lo      (core_lo),
        .init_operand (core_operand),
        .last_step    (core_last),
        .acc          (core_acc)
    );

    assign core_step     = (state_q == S_MUL) || (state_q == S_DIV);
    assign core_mode_div = (state_q == S_DIV);

    assign sgn      = op_is_signed(op);
    assign prod_neg = ~core_acc + 1'b1;
    assign quot     = core_acc[WIDTH-1:0];
    assign rem      = core_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        dbz_d        = 1'b0;
        pend_dbz_d   = pend_dbz_q;
        div_d        = div_q;
        neg_lo_d     = neg_lo_q;
        neg_hi_d     = neg_hi_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        core_init    = 1'b0;
        core_lo      = '0;
        core_operand = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == HILO_MTHI) begin
                        hi_d   = a;
                        done_d = 1'b1;
                    end else if (op == HILO_MTLO) begin
                        lo_d   = a;
                        done_d = 1'b1;
                    end else if (op_is_mul(op)) begin
                        core_init    = 1'b1;
                        core_lo      = mag(b, sgn);
                        core_operand = mag(a, sgn);
                        neg_lo_d     = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_hi_d     = 1'b0;
                        div_d        = 1'b0;
                        pend_dbz_d   = 1'b0;
                        busy_d       = 1'b1;
                        state_d      = S_MUL;
                    end else if (op_is_div(op)) begin
                        div_d    = 1'b1;
                        busy_d   = 1'b1;
                        neg_lo_d = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_hi_d = sgn && a[WIDTH-1];
                        // A zero divisor skips iteration and reports through FIX one edge later.
                        if (b == '0) begin
                            pend_dbz_d = 1'b1;
                            state_d    = S_FIX;
                        end else begin
                            core_init    = 1'b1;
                            core_lo      = mag(a, sgn);
                            core_operand = mag(b, sgn);
                            pend_dbz_d   = 1'b0;
                            state_d      = S_DIV;
                        end
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (core_last) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d    = S_IDLE;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                pend_dbz_d = 1'b0;
                if (pend_dbz_q) begin
                    dbz_d = 1'b1;
                end else if (div_q) begin
                    lo_d = neg_lo_q ? (~quot + 1'b1) : quot;
                    hi_d = neg_hi_q ? (~rem + 1'b1) : rem;
                end else begin
                    {hi_d, lo_d} = neg_lo_q ? prod_neg : core_acc;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            pend_dbz_q <= 1'b0;
            div_q      <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            pend_dbz_q <= pend_dbz_d;
            div_q      <= div_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - self-checking bench for hilo_muldiv_unit against an arithmetic model
module tb_hilo_muldiv_unit;
    import hilo_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [W-1:0] hi_m;
    logic [W-1:0] lo_m;
    bit           dbz_m;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic ref_model(input logic [2:0] m_op, input logic [W-1:0] ma, input logic [W-1:0] mb);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        dbz_m = 1'b0;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        ua = {32'b0, ma};
        ub = {32'b0, mb};
        case (m_op)
            HILO_MULT:  begin p = longint'(sa * sb); hi_m = p[63:32]; lo_m = p[31:0]; end
            HILO_MULTU: begin p = ua * ub;           hi_m = p[63:32]; lo_m = p[31:0]; end
            HILO_DIV: begin
                if (mb == 0) dbz_m = 1'b1;
                else begin q = sa / sb; r = sa % sb; lo_m = q[31:0]; hi_m = r[31:0]; end
            end
            HILO_DIVU: begin
                if (mb == 0) dbz_m = 1'b1;
                else begin p = ua / ub; lo_m = p[31:0]; p = ua % ub; hi_m = p[31:0]; end
            end
            HILO_MTHI: hi_m = ma;
            HILO_MTLO: lo_m = ma;
            default: ;
        endcase
    endtask

    // Called between edges; returns at posedge+1 in the done cycle so a follow-up op issues back-to-back.
    task automatic do_op(input logic [2:0] d_op, input logic [W-1:0] da, input logic [W-1:0] db,
                         output int busy_cycles, output bit got_done, output bit got_dbz);
        int cycles;
        ref_model(d_op, da, db);
        start = 1'b1; op = d_op; a = da; b = db;
        @(posedge clk); #1;
        start = 1'b0; op = HILO_NOP;
        cycles = 0; busy_cycles = 0; got_done = 0; got_dbz = 0;
        while (!got_done && cycles < 100) begin
            if (done) begin
                got_done = 1;
                got_dbz  = div_by_zero;
            end else begin
                if (busy) busy_cycles++;
                @(posedge clk); #1;
                cycles++;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; op = HILO_NOP; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (hi !== '0)          $display("FAIL reset_hi: got %h want 0", hi); else pass_cnt++;
        total_cnt++; if (lo !== '0)          $display("FAIL reset_lo: got %h want 0", lo); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0)      $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0)      $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        total_cnt++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz: got %b want 0", div_by_zero); else pass_cnt++;
        hi_m = '0; lo_m = '0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_multu_max;
        int bc; bit gd, gz;
        do_op(HILO_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, gd, gz);
        total_cnt++; if (!gd)                 $display("FAIL multu_done: timeout"); else pass_cnt++;
        total_cnt++; if (bc != 33)            $display("FAIL multu_busy_cycles: got %0d want 33", bc); else pass_cnt++;
        total_cnt++; if (hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi: got %h want fffffffe", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'h0000_0001) $display("FAIL multu_lo: got %h want 00000001", lo); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (done !== 1'b0)       $display("FAIL multu_done_width: got %b want 0", done); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int bc; bit gd, gz;
        do_op(HILO_MULT, 32'hFFFF_FFFD, 32'd5, bc, gd, gz);
        total_cnt++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_neg_hi: got %h want ffffffff", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'hFFFF_FFF1) $display("FAIL mult_neg_lo: got %h want fffffff1", lo); else pass_cnt++;
        do_op(HILO_MTLO, 32'h55, 32'h0, bc, gd, gz);
        total_cnt++; if (!gd || bc != 0)       $display("FAIL mtlo_b2b_timing: done %b busy_cycles %0d want 1/0", gd, bc); else pass_cnt++;
        total_cnt++; if (lo !== 32'h55)        $display("FAIL mtlo_b2b_lo: got %h want 00000055", lo); else pass_cnt++;
        total_cnt++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mtlo_b2b_hi: got %h want ffffffff", hi); else pass_cnt++;
    endtask

    task automatic test_divide;
        int bc; bit gd, gz;
        do_op(HILO_DIV, 32'hFFFF_FFF9, 32'd2, bc, gd, gz);
        total_cnt++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF)
            $display("FAIL div_signed: got hi=%h lo=%h want hi=ffffffff lo=fffffffd", hi, lo); else pass_cnt++;
        do_op(HILO_DIVU, 32'd7, 32'd2, bc, gd, gz);
        total_cnt++; if (lo !== 32'd3 || hi !== 32'd1)
            $display("FAIL divu_small: got hi=%h lo=%h want hi=1 lo=3", hi, lo); else pass_cnt++;
        total_cnt++; if (bc != 33 || gz)      $display("FAIL divu_timing: busy %0d dbz %b want 33/0", bc, gz); else pass_cnt++;
        do_op(HILO_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc, gd, gz);
        total_cnt++; if (lo !== 32'h8000_0000 || hi !== 32'h0)
            $display("FAIL div_overflow: got hi=%h lo=%h want hi=0 lo=80000000", hi, lo); else pass_cnt++;
    endtask

    task automatic test_div_by_zero;
        int bc; bit gd, gz;
        do_op(HILO_MTHI, 32'hA, 32'h0, bc, gd, gz);
        do_op(HILO_MTLO, 32'hB, 32'h0, bc, gd, gz);
        do_op(HILO_DIVU, 32'h1234, 32'h0, bc, gd, gz);
        total_cnt++; if (!gd || !gz)          $display("FAIL dbz_pulse: done %b dbz %b want 1/1", gd, gz); else pass_cnt++;
        total_cnt++; if (bc != 1)             $display("FAIL dbz_busy: got %0d want 1", bc); else pass_cnt++;
        total_cnt++; if (hi !== 32'hA || lo !== 32'hB)
            $display("FAIL dbz_hold: got hi=%h lo=%h want hi=a lo=b", hi, lo); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (div_by_zero !== 1'b0 || done !== 1'b0)
            $display("FAIL dbz_width: dbz %b done %b want 0/0", div_by_zero, done); else pass_cnt++;
    endtask

    task automatic test_busy_ignore;
        int bc, cycles, hi_bad; bit gd, gz;
        do_op(HILO_MTHI, 32'h1234, 32'h0, bc, gd, gz);
        ref_model(HILO_MULT, 32'd3, 32'hFFFF_FFFC);
        start = 1'b1; op = HILO_MULT; a = 32'd3; b = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        start = 1'b0; op = HILO_NOP;
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b1; op = HILO_MTLO; a = 32'h99;
        @(posedge clk); #1;
        start = 1'b0; op = HILO_NOP;
        cycles = 0; hi_bad = 0;
        while (!done && cycles < 100) begin
            if (hi !== 32'h1234) hi_bad++;
            @(posedge clk); #1;
            cycles++;
        end
        total_cnt++; if (!done)               $display("FAIL busy_ignore_done: timeout"); else pass_cnt++;
        total_cnt++; if (hi_bad != 0)         $display("FAIL busy_ignore_hi_hold: %0d cycles with hi != 1234", hi_bad); else pass_cnt++;
        total_cnt++; if (lo !== 32'hFFFF_FFF4) $display("FAIL busy_ignore_lo: got %h want fffffff4", lo); else pass_cnt++;
        total_cnt++; if (hi !== 32'hFFFF_FFFF) $display("FAIL busy_ignore_hi: got %h want ffffffff", hi); else pass_cnt++;
    endtask

    task automatic test_async_reset;
        int bc; bit gd, gz;
        do_op(HILO_MTHI, 32'hDEAD, 32'h0, bc, gd, gz);
        do_op(HILO_MTLO, 32'hBEEF, 32'h0, bc, gd, gz);
        start = 1'b1; op = HILO_MULT; a = 32'h12345; b = 32'h777;
        @(posedge clk); #1;
        start = 1'b0; op = HILO_NOP;
        repeat (10) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (hi !== '0 || lo !== '0)
            $display("FAIL async_reset_hilo: got hi=%h lo=%h want 0/0", hi, lo); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL async_reset_ctrl: busy %b done %b want 0/0", busy, done); else pass_cnt++;
        hi_m = '0; lo_m = '0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(HILO_MULTU, 32'd6, 32'd7, bc, gd, gz);
        total_cnt++; if (!gd || bc != 33 || lo !== 32'd42 || hi !== 32'd0)
            $display("FAIL post_reset_mult: done %b busy %0d hi=%h lo=%h want 1/33/0/2a", gd, bc, hi, lo); else pass_cnt++;
    endtask

    task automatic test_ignored_ops;
        logic [W-1:0] h0, l0;
        int           seen;
        h0 = hi_m; l0 = lo_m;
        seen = 0;
        for (int k = 0; k < 2; k++) begin
            start = 1'b1; op = (k == 0) ? 3'd0 : 3'd7; a = $urandom; b = $urandom;
            @(posedge clk); #1;
            start = 1'b0; op = HILO_NOP;
            repeat (3) begin
                if (busy || done) seen++;
                @(posedge clk); #1;
            end
        end
        total_cnt++; if (seen != 0)           $display("FAIL ignored_op_activity: %0d busy/done cycles want 0", seen); else pass_cnt++;
        total_cnt++; if (hi !== h0 || lo !== l0)
            $display("FAIL ignored_op_hilo: got hi=%h lo=%h want hi=%h lo=%h", hi, lo, h0, l0); else pass_cnt++;
    endtask

    task automatic test_random;
        int bc; bit gd, gz;
        logic [2:0]   r_op;
        logic [W-1:0] ra, rb;
        for (int i = 0; i < 60; i++) begin
            r_op = 3'($urandom_range(1, 6));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            do_op(r_op, ra, rb, bc, gd, gz);
            total_cnt++;
            if (!gd || gz !== dbz_m || hi !== hi_m || lo !== lo_m)
                $display("FAIL random_%0d op=%0d a=%h b=%h: done %b dbz %b hi=%h lo=%h want dbz %b hi=%h lo=%h",
                         i, r_op, ra, rb, gd, gz, hi, lo, dbz_m, hi_m, lo_m);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_back_to_back();
        test_divide();
        test_div_by_zero();
        test_busy_ignore();
        test_async_reset();
        test_ignored_ops();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
